ripp_serial_sub: RTL and testbench



---
 rtl/ripp_serial_sub.sv | 100 ++++++++++
 tb/tb_ripp_serial_sub.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ripp_serial_sub.sv
// Bit-serial ripple subtractor: one full-subtractor cell processes a bit per clock, LSB first.
// A borrow flip-flop takes the place of the ripple chain; D/Bout update only when the operation completes.
module ripp_serial_sub #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_bin,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_d,
    output logic         o_bout
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_a_sh;
    logic [W-1:0]  r_b_sh;
    logic [W-1:0]  r_res;
    logic          r_br;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic [W-1:0]  r_d;
    logic          r_bout;

    logic          w_a;
    logic          w_b;
    logic          w_diff;
    logic          w_borrow_next;
    logic [W-1:0]  w_res_next;

    assign w_a           = r_a_sh[0];
    assign w_b           = r_b_sh[0];
    assign w_diff        = w_a ^ w_b ^ r_br;
    assign w_borrow_next = (~w_a & w_b) | (~w_a & r_br) | (w_b & r_br);
    // The result register fills from the top, so after W shifts bit 0 is the first difference bit.
    assign w_res_next    = {w_diff, r_res[W-1:1]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_d     <= '0;
            r_bout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a_sh  <= i_a;
                        r_b_sh  <= i_b;
                        r_br    <= i_bin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_res  <= w_res_next;
                    r_br   <= w_borrow_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_d     <= w_res_next;
                        r_bout  <= w_borrow_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_d    = r_d;
    assign o_bout = r_bout;

endmodule

// File: tb/tb_ripp_serial_sub.sv
// Testbench for ripp_serial_sub (W = 4): fixed vectors, handshake/reset sequences, and random operands
// checked against a plain-arithmetic reference.
module tb_ripp_serial_sub;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         bin_in;
    logic         busy;
    logic         done;
    logic [W-1:0] d_out;
    logic         bout;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] prev_d;
    logic         prev_bout;

    ripp_serial_sub #(.W(W)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .i_a    (a_in),
        .i_b    (b_in),
        .i_bin  (bin_in),
        .o_busy (busy),
        .o_done (done),
        .o_d    (d_out),
        .o_bout (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_d;
        logic         exp_bout;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // {Bout, D} is the (W+1)-bit two's complement of A - B - Bin.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int r;
        r = int'(a) - int'(b) - int'(bin);
        return r[W:0];
    endfunction

    // Called at the negedge after an accept edge; returns edges until done (0 if none within bound).
    task automatic wait_done(input string nm, output int lat);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            chk({nm, " d_hold"}, int'(d_out), int'(prev_d));
            chk({nm, " bout_hold"}, int'(bout), int'(prev_bout));
        end
    endtask

    task automatic finish_check(input string nm, input int lat, input logic [W-1:0] ed, input logic eb);
        chk({nm, " latency"}, lat, W);
        chk({nm, " d"}, int'(d_out), int'(ed));
        chk({nm, " bout"}, int'(bout), int'(eb));
        chk({nm, " busy_at_done"}, int'(busy), 0);
        prev_d    = ed;
        prev_bout = eb;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic [W-1:0] ed, input logic eb, input string nm);
        int lat;
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; bin_in = bin;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        bin_in = 1'($urandom);
        chk({nm, " busy"}, int'(busy), 1);
        wait_done(nm, lat);
        finish_check(nm, lat, ed, eb);
        @(negedge clk);
        chk({nm, " done_pulse"}, int'(done), 0);
        chk({nm, " busy_after"}, int'(busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prev_d = '0; prev_bout = 1'b0;
    endtask

    initial begin
        int lat;
        logic [W:0] e;
        logic [W-1:0] ra, rb;
        logic rbin;

        vecs[0] = '{4'h1, 4'h0, 1'b0, 4'b0001, 1'b0};
        vecs[1] = '{4'h2, 4'h4, 1'b1, 4'b1101, 1'b1};
        vecs[2] = '{4'h6, 4'h6, 1'b0, 4'b0000, 1'b0};
        vecs[3] = '{4'h5, 4'h3, 1'b1, 4'b0001, 1'b0};
        vecs[4] = '{4'h0, 4'h0, 1'b1, 4'b1111, 1'b1};
        vecs[5] = '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b0};
        vecs[6] = '{4'h0, 4'hF, 1'b1, 4'b0000, 1'b1};

        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; bin_in = 1'b0;
        do_reset();

        @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst d", int'(d_out), 0);
        chk("rst bout", int'(bout), 0);

        a_in = 4'd7; b_in = 4'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle busy", int'(busy), 0);
            chk("idle done", int'(done), 0);
            chk("idle d", int'(d_out), 0);
        end

        for (int i = 0; i < 7; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_d, vecs[i].exp_bout,
                  $sformatf("vec%0d", i));

        // start pulsed while busy must be ignored: one done, then quiet
        @(negedge clk);
        start = 1'b1; a_in = 4'hA; b_in = 4'h3; bin_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a_in = 4'h1; b_in = 4'h8;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int i = 3; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
        end
        e = ref_sub(4'hA, 4'h3, 1'b0);
        finish_check("busy_start", lat, e[W-1:0], e[W]);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("busy_start extra_done", int'(done), 0);
            chk("busy_start extra_busy", int'(busy), 0);
        end

        // start held high: back-to-back with re-sampled operands
        @(negedge clk);
        start = 1'b1; a_in = 4'd3; b_in = 4'd5; bin_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_in = 4'd12; b_in = 4'd4; bin_in = 1'b1;
        wait_done("b2b first", lat);
        e = ref_sub(4'd3, 4'd5, 1'b0);
        finish_check("b2b first", lat, e[W-1:0], e[W]);
        @(posedge clk);
        @(negedge clk);
        chk("b2b busy_regained", int'(busy), 1);
        chk("b2b done_cleared", int'(done), 0);
        start = 1'b0; a_in = 4'h0; b_in = 4'hF;
        wait_done("b2b second", lat);
        e = ref_sub(4'd12, 4'd4, 1'b1);
        finish_check("b2b second", lat, e[W-1:0], e[W]);

        // reset two edges after accept
        @(negedge clk);
        start = 1'b1; a_in = 4'hF; b_in = 4'h1; bin_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst d", int'(d_out), 0);
        chk("midrst bout", int'(bout), 0);
        @(negedge clk);
        rst = 1'b0;
        prev_d = '0; prev_bout = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst no_done", int'(done), 0);
            chk("midrst no_busy", int'(busy), 0);
        end
        do_op(4'd9, 4'd4, 1'b0, 4'b0101, 1'b0, "after_rst");

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
            e = ref_sub(ra, rb, rbin);
            do_op(ra, rb, rbin, e[W-1:0], e[W], $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
